stq_alloc_ctl: RTL and testbench

In-order allocation, commit and drain controller for the 64-entry store-queue address array. It owns the head, commit and tail pointers of the circular queue. It produces the per-entry one-hot strobes consumed by the array: wrt0_en/wrt1_en, passe_en and free_en. It also flushes uncommitted entries on exception.

---
 rtl/stq_pkg.sv | 29 ++
 rtl/stq_range_mask.sv | 21 ++
 rtl/stq_alloc_ctl.sv | 110 +++++++++++
 tb/tb_stq_alloc_ctl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stq_pkg.sv
// Store-queue allocation controller shared types.
// Pointers carry one wrap bit above the entry index.
package stq_pkg;
  localparam int BUF_COUNT = 64;
  localparam int IDW = 6;

  typedef logic [IDW:0] ptr_t;
  typedef logic [IDW-1:0] idx_t;
  typedef logic [BUF_COUNT-1:0] vec_t;

  typedef struct packed {
    vec_t wrt0;
    vec_t wrt1;
    vec_t passe;
    vec_t free;
  } strb_t;

  function automatic vec_t onehot(input idx_t idx);
    vec_t v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Bits strictly below idx set.
  function automatic vec_t therm(input idx_t idx);
    return onehot(idx) - vec_t'(1);
  endfunction
endpackage

// File: rtl/stq_range_mask.sv
// Wrap-aware mask of entries in [start_ptr, end_ptr).
// Equal indices with differing wrap bits select every entry.
module stq_range_mask
  import stq_pkg::*;
(
  input  logic [IDW:0]       start_ptr,
  input  logic [IDW:0]       end_ptr,
  output logic [BUF_COUNT-1:0] mask
);
  ptr_t len;
  vec_t span;
  logic wraps;

  always_comb begin
    len = end_ptr - start_ptr;
    span = therm(start_ptr[IDW-1:0]) ^ therm(end_ptr[IDW-1:0]);
    wraps = (len != '0) &&
            (end_ptr[IDW-1:0] <= start_ptr[IDW-1:0]);
    mask = wraps ? ~span : span;
  end
endmodule

// File: rtl/stq_alloc_ctl.sv
// Store-queue head/commit/tail pointer control with
// per-entry write, commit and release strobes.
module stq_alloc_ctl
  import stq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallA,
  input  logic                 excpt,
  input  logic [1:0]           alloc_req,
  output logic                 alloc_gnt,
  output logic [IDW-1:0]       alloc_id0,
  output logic [IDW-1:0]       alloc_id1,
  input  logic                 agu0_vld,
  input  logic [IDW-1:0]       agu0_id,
  input  logic                 agu1_vld,
  input  logic [IDW-1:0]       agu1_id,
  output logic [BUF_COUNT-1:0] wrt0_en,
  output logic [BUF_COUNT-1:0] wrt1_en,
  input  logic [1:0]           cmt_cnt,
  output logic [BUF_COUNT-1:0] passe_en,
  output logic                 drain_vld,
  output logic [IDW-1:0]       drain_id,
  input  logic                 drain_ack,
  output logic [BUF_COUNT-1:0] free_en,
  output logic [IDW:0]         count,
  output logic                 full
);
  ptr_t head_q, head_d;
  ptr_t cmt_q, cmt_d;
  ptr_t tail_q, tail_d;
  strb_t strb_q, strb_d;

  ptr_t cnt;
  ptr_t space;
  logic drain_go;
  vec_t passe_mask;
  vec_t flush_mask;

  stq_range_mask u_passe (
    .start_ptr (cmt_q),
    .end_ptr   (cmt_d),
    .mask      (passe_mask)
  );

  // Flush runs from the post-commit pointer to the old tail.
  stq_range_mask u_flush (
    .start_ptr (cmt_d),
    .end_ptr   (tail_q),
    .mask      (flush_mask)
  );

  always_comb begin
    cnt = tail_q - head_q;
    space = ptr_t'(BUF_COUNT) - cnt;
    count = cnt;
    full = cnt[IDW];
    alloc_gnt = ~rst & (alloc_req != 2'd0) & ~stallA &
                ~excpt & (space >= ptr_t'(alloc_req));
    alloc_id0 = tail_q[IDW-1:0];
    alloc_id1 = tail_q[IDW-1:0] + idx_t'(1);
    drain_vld = head_q != cmt_q;
    drain_id = head_q[IDW-1:0];
    drain_go = drain_vld & drain_ack;
  end

  always_comb begin
    cmt_d = cmt_q + ptr_t'(cmt_cnt);
    head_d = head_q + ptr_t'(drain_go);
    tail_d = tail_q;
    unique case (1'b1)
      excpt:     tail_d = cmt_d;
      alloc_gnt: tail_d = tail_q + ptr_t'(alloc_req);
      default:   tail_d = tail_q;
    endcase
  end

  always_comb begin
    strb_d.wrt0 = (agu0_vld & ~excpt) ? onehot(agu0_id) : '0;
    strb_d.wrt1 = (agu1_vld & ~excpt) ? onehot(agu1_id) : '0;
    strb_d.passe = passe_mask;
    strb_d.free = (excpt ? flush_mask : '0) |
                  (drain_go ? onehot(head_q[IDW-1:0]) : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      cmt_q <= '0;
      tail_q <= '0;
      strb_q <= '0;
    end else begin
      head_q <= head_d;
      cmt_q <= cmt_d;
      tail_q <= tail_d;
      strb_q <= strb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (ptr_t'(cmt_cnt) <= ptr_t'(tail_q - cmt_q));
    end
  end

  assign wrt0_en = strb_q.wrt0;
  assign wrt1_en = strb_q.wrt1;
  assign passe_en = strb_q.passe;
  assign free_en = strb_q.free;
endmodule

// File: tb/tb_stq_alloc_ctl.sv
// Self-checking bench for stq_alloc_ctl: pointer model,
// strobe scoreboard, vector table and corner sequences.
module tb_stq_alloc_ctl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stallA = 1'b0;
  logic excpt = 1'b0;
  logic [1:0] alloc_req = '0;
  logic alloc_gnt;
  logic [5:0] alloc_id0, alloc_id1;
  logic agu0_vld = 1'b0;
  logic [5:0] agu0_id = '0;
  logic agu1_vld = 1'b0;
  logic [5:0] agu1_id = '0;
  logic [63:0] wrt0_en, wrt1_en, passe_en, free_en;
  logic [1:0] cmt_cnt = '0;
  logic drain_vld;
  logic [5:0] drain_id;
  logic drain_ack = 1'b0;
  logic [6:0] count;
  logic full;

  stq_alloc_ctl dut (
    .clk(clk), .rst(rst), .stallA(stallA), .excpt(excpt),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_id0(alloc_id0), .alloc_id1(alloc_id1),
    .agu0_vld(agu0_vld), .agu0_id(agu0_id),
    .agu1_vld(agu1_vld), .agu1_id(agu1_id),
    .wrt0_en(wrt0_en), .wrt1_en(wrt1_en),
    .cmt_cnt(cmt_cnt), .passe_en(passe_en),
    .drain_vld(drain_vld), .drain_id(drain_id),
    .drain_ack(drain_ack), .free_en(free_en),
    .count(count), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] w0;
    logic [63:0] w1;
    logic [63:0] ps;
    logic [63:0] fr;
  } exp_t;

  typedef struct {
    int areq; int st; int ex; int cc;
    logic eg; int eid0; int ecnt;
  } tvec_t;

  exp_t sbq[$];
  int n_chk = 0;
  int n_fail = 0;
  int m_head, m_cmt, m_tail;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] bit1(input int i);
    logic [63:0] m;
    m = '0;
    m[i % 64] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] rng(input int s, input int e);
    logic [63:0] m;
    m = '0;
    for (int p = s; p != e; p = (p + 1) % 128) m[p % 64] = 1'b1;
    return m;
  endfunction

  task automatic idle();
    stallA = 0; excpt = 0; alloc_req = 0; cmt_cnt = 0;
    agu0_vld = 0; agu1_vld = 0; drain_ack = 0;
  endtask

  task automatic do_reset(input bit dirty);
    rst = 1;
    if (dirty) begin
      agu0_vld = 1; agu1_vld = 1; alloc_req = 2;
      drain_ack = 1; cmt_cnt = 1;
      #1 chk("gnt_in_reset", 64'(alloc_gnt), 64'd0);
    end
    @(posedge clk); #1;
    rst = 0;
    idle();
    sbq.delete();
    m_head = 0; m_cmt = 0; m_tail = 0;
    #1;
    chk("rst_wrt0", wrt0_en, '0);
    chk("rst_wrt1", wrt1_en, '0);
    chk("rst_passe", passe_en, '0);
    chk("rst_free", free_en, '0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_drain_vld", 64'(drain_vld), 64'd0);
    chk("rst_gnt", 64'(alloc_gnt), 64'd0);
  endtask

  task automatic step(input int areq, input int st, input int ex,
                      input int v0, input int i0, input int v1,
                      input int i1, input int cc, input int dk,
                      output logic og, output int oid0,
                      output int ocnt);
    int cnt, cn;
    logic g, dv;
    exp_t e;
    alloc_req = 2'(areq); stallA = st[0]; excpt = ex[0];
    agu0_vld = v0[0]; agu0_id = 6'(i0);
    agu1_vld = v1[0]; agu1_id = 6'(i1);
    cmt_cnt = 2'(cc); drain_ack = dk[0];
    #1;
    og = alloc_gnt; oid0 = int'(alloc_id0); ocnt = int'(count);
    cnt = (m_tail - m_head + 128) % 128;
    g = (areq != 0) && (st == 0) && (ex == 0) && (64 - cnt >= areq);
    dv = m_head != m_cmt;
    chk("alloc_gnt", 64'(alloc_gnt), 64'(g));
    chk("count", 64'(count), 64'(cnt));
    chk("full", 64'(full), 64'(cnt == 64));
    chk("drain_vld", 64'(drain_vld), 64'(dv));
    if (dv) chk("drain_id", 64'(drain_id), 64'(m_head % 64));
    if (g) begin
      chk("alloc_id0", 64'(alloc_id0), 64'(m_tail % 64));
      chk("alloc_id1", 64'(alloc_id1), 64'((m_tail + 1) % 64));
    end
    e.w0 = (v0 != 0 && ex == 0) ? bit1(i0) : '0;
    e.w1 = (v1 != 0 && ex == 0) ? bit1(i1) : '0;
    cn = (m_cmt + cc) % 128;
    e.ps = rng(m_cmt, cn);
    e.fr = (dk != 0 && dv) ? bit1(m_head) : '0;
    if (ex != 0) e.fr |= rng(cn, m_tail);
    if (ex != 0) m_tail = cn;
    else if (g) m_tail = (m_tail + areq) % 128;
    if (dk != 0 && dv) m_head = (m_head + 1) % 128;
    m_cmt = cn;
    sbq.push_back(e);
    @(posedge clk); #1;
    idle();
    e = sbq.pop_front();
    chk("wrt0_en", wrt0_en, e.w0);
    chk("wrt1_en", wrt1_en, e.w1);
    chk("passe_en", passe_en, e.ps);
    chk("free_en", free_en, e.fr);
  endtask

  tvec_t tbl[6];
  logic g;
  int id0, cnt;

  initial begin
    tbl[0] = '{2, 0, 0, 0, 1'b1, 0, 0};
    tbl[1] = '{1, 1, 0, 0, 1'b0, 2, 2};
    tbl[2] = '{1, 0, 0, 0, 1'b1, 2, 2};
    tbl[3] = '{2, 0, 0, 1, 1'b1, 3, 3};
    tbl[4] = '{2, 0, 1, 1, 1'b0, 5, 5};
    tbl[5] = '{0, 0, 0, 0, 1'b0, 2, 2};

    do_reset(0);
    foreach (tbl[i]) begin
      step(tbl[i].areq, tbl[i].st, tbl[i].ex, 0, 0, 0, 0,
           tbl[i].cc, 0, g, id0, cnt);
      chk("tbl_gnt", 64'(g), 64'(tbl[i].eg));
      chk("tbl_id0", 64'(id0), 64'(tbl[i].eid0));
      chk("tbl_cnt", 64'(cnt), 64'(tbl[i].ecnt));
    end

    // Fill to 63, refuse a pair, accept a single, then full.
    do_reset(0);
    for (int i = 0; i < 31; i++) step(2, 0, 0, 0, 0, 0, 0, 0, 0, g, id0, cnt);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, g, id0, cnt);
    step(2, 0, 0, 0, 0, 0, 0, 0, 0, g, id0, cnt);
    chk("c63_gnt2", 64'(g), 64'd0);
    chk("c63_cnt", 64'(cnt), 64'd63);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, g, id0, cnt);
    chk("c63_gnt1", 64'(g), 64'd1);
    chk("c63_id0", 64'(id0), 64'd63);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, g, id0, cnt);
    chk("full_gnt", 64'(g), 64'd0);
    chk("full_cnt", 64'(cnt), 64'd64);
    chk("full_flag", 64'(full), 64'd1);

    step(0, 0, 0, 1, 5, 1, 63, 0, 0, g, id0, cnt);
    chk("agu_w0", wrt0_en, 64'h0000_0000_0000_0020);
    chk("agu_w1", wrt1_en, 64'h8000_0000_0000_0000);
    step(0, 0, 0, 1, 9, 1, 9, 0, 0, g, id0, cnt);
    step(0, 0, 1, 1, 7, 1, 8, 0, 0, g, id0, cnt);

    // Flush with same-cycle commit.
    do_reset(1);
    for (int i = 0; i < 5; i++) step(2, 0, 0, 0, 0, 0, 0, 0, 0, g, id0, cnt);
    step(0, 0, 0, 0, 0, 0, 0, 2, 0, g, id0, cnt);
    step(0, 0, 0, 0, 0, 0, 0, 2, 0, g, id0, cnt);
    step(1, 0, 1, 0, 0, 0, 0, 2, 0, g, id0, cnt);
    chk("ex_passe", passe_en, 64'h0000_0000_0000_0030);
    chk("ex_free", free_en, 64'h0000_0000_0000_03C0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, g, id0, cnt);
    chk("ex_tail", 64'(id0), 64'd6);
    chk("ex_cnt", 64'(cnt), 64'd6);

    // Wrapped flush: head=cmt=60, tail=68.
    do_reset(0);
    for (int i = 0; i < 30; i++) step(2, 0, 0, 0, 0, 0, 0, 0, 0, g, id0, cnt);
    for (int i = 0; i < 60; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 1, g, id0, cnt);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, g, id0, cnt);
    for (int i = 0; i < 4; i++) step(2, 0, 0, 0, 0, 0, 0, 0, 0, g, id0, cnt);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, g, id0, cnt);
    chk("wrap_free", free_en, 64'hF000_0000_0000_000F);
    chk("wrap_cnt", 64'(count), 64'd0);
    chk("wrap_dvld", 64'(drain_vld), 64'd0);

    // Single drain, then an ignored ack.
    step(2, 0, 0, 0, 0, 0, 0, 0, 0, g, id0, cnt);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, g, id0, cnt);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, g, id0, cnt);
    chk("drain_free", free_en, 64'h1000_0000_0000_0000);
    chk("drain_vld_off", 64'(drain_vld), 64'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, g, id0, cnt);
    chk("drain_ignored", free_en, 64'd0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, g, id0, cnt);

    for (int i = 0; i < 400; i++) begin
      int room, cc;
      room = (m_tail - m_cmt + 128) % 128;
      cc = $urandom_range(0, room < 2 ? room : 2);
      step($urandom_range(0, 2), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 15) == 0), $urandom_range(0, 1),
           $urandom_range(0, 63), $urandom_range(0, 1),
           $urandom_range(0, 63), cc, $urandom_range(0, 1),
           g, id0, cnt);
    end

    step(0, 0, 0, 1, 3, 1, 4, 0, 0, g, id0, cnt);
    agu0_vld = 1; agu1_vld = 1;
    do_reset(1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
